// File: rtl/syn_current_accum.sv
// Synaptic current accumulator feeding the LIF neuron's syn_i input.
// Sums weighted presynaptic spikes into a saturating current with periodic shift-based decay.
module syn_current_accum #(
  parameter int unsigned N_IN        = 4,
  parameter int unsigned W_W         = 8,
  parameter int unsigned OUT_W       = 10,
  parameter int unsigned DECAY_SHIFT = 3
) (
  input  logic                      clk_in,
  input  logic                      reset,
  input  logic [N_IN-1:0]           pre_spike,
  input  logic                      wt_we,
  input  logic [$clog2(N_IN)-1:0]   wt_addr,
  input  logic [W_W-1:0]            wt_data,
  input  logic [8:0]                decay_rate,
  output logic [OUT_W-1:0]          syn_o,
  output logic                      sat_flag
);

  localparam int unsigned AW    = $clog2(N_IN);
  localparam int unsigned CNT_W = 9;
  localparam int unsigned SUM_W = W_W + AW;
  localparam int unsigned NXT_W = ((SUM_W > OUT_W) ? SUM_W : OUT_W) + 1;
  localparam logic [OUT_W-1:0] ACC_MAX = '1;

  logic [W_W-1:0]   weight [N_IN];
  logic [CNT_W-1:0] cnt;

  logic             tick_c;
  logic [OUT_W-1:0] shifted_c;
  logic [OUT_W-1:0] dec_c;
  logic [SUM_W-1:0] sum_c;
  logic [NXT_W-1:0] nxt_c;

  // Weight table: a write lands at the edge, so a same-cycle spike still sees the old value.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      for (int i = 0; i < N_IN; i++) begin
        weight[i] <= '0;
      end
    end else if (wt_we) begin
      weight[wt_addr] <= wt_data;
    end
  end

  // Free-running decay timer; a lowered period below the current count wraps through max.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      cnt <= '0;
    end else if (tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick_c = (cnt == decay_rate);

  // Decrement with a floor of one so a small nonzero current always drains to zero.
  always_comb begin
    shifted_c = syn_o >> DECAY_SHIFT;
    dec_c     = '0;
    if (tick_c) begin
      if ((syn_o != '0) && (shifted_c == '0)) begin
        dec_c = OUT_W'(1);
      end else begin
        dec_c = shifted_c;
      end
    end
  end

  // Sum every active input; width covers all weights at max without wrap.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (pre_spike[i]) begin
        sum_c = sum_c + SUM_W'(weight[i]);
      end
    end
  end

  assign nxt_c = NXT_W'(syn_o - dec_c) + NXT_W'(sum_c);

  // Accumulator doubles as the output register; clamp only at the top.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      syn_o    <= '0;
      sat_flag <= 1'b0;
    end else if (nxt_c > NXT_W'(ACC_MAX)) begin
      syn_o    <= ACC_MAX;
      sat_flag <= 1'b1;
    end else begin
      syn_o    <= OUT_W'(nxt_c);
      sat_flag <= 1'b0;
    end
  end

endmodule
